// File: rtl/pmp_check_pipe_if.sv
// pmp_check_pipe_if: riscv PMP types plus the req/rsp handshake bundle (master drives req, slave answers rsp)
package riscv;
  typedef logic [2:0] pmp_access_t;
  typedef enum logic [1:0] {PRIV_LVL_U = 2'b00, PRIV_LVL_S = 2'b01, PRIV_LVL_M = 2'b11} priv_lvl_t;
  typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_addr_mode_t;
  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmp_access_t    access_type;
  } pmpcfg_t;
endpackage

interface pmp_check_pipe_if #(
  parameter int PLEN  = 34,
  parameter int IDX_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [PLEN-1:0]   req_addr;
  riscv::pmp_access_t req_access;
  riscv::priv_lvl_t  req_priv;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_allow;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;
  modport master (
    output req_valid, req_addr, req_access, req_priv, rsp_ready,
    input  req_ready, rsp_valid, rsp_allow, rsp_hit, rsp_idx
  );
  modport slave (
    input  req_valid, req_addr, req_access, req_priv, rsp_ready,
    output req_ready, rsp_valid, rsp_allow, rsp_hit, rsp_idx
  );
endinterface

// File: rtl/pmp_check_pipe.sv
// pmp_check_pipe: 2-stage PMP checker; bus = req/rsp handshakes, conf_* = pmpaddr/pmpcfg tables, fault_*/deny_count_o = denial log
module pmp_check_pipe #(
  parameter int PLEN = 34,
  parameter int PMP_LEN = 32,
  parameter int NR_ENTRIES = 16,
  parameter int IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
  parameter int CNT_W = 16,
  localparam int NE = (NR_ENTRIES > 0) ? NR_ENTRIES : 1,
  localparam int AW = PLEN - 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pmp_check_pipe_if.slave     bus,
  input  logic [PMP_LEN-1:0]  conf_addr_i [NE],
  input  riscv::pmpcfg_t      conf_i [NE],
  input  logic                fault_clear_i,
  output logic                fault_valid_o,
  output logic [PLEN-1:0]     fault_addr_o,
  output logic [IDX_W-1:0]    fault_idx_o,
  output logic                fault_hit_o,
  output logic [CNT_W-1:0]    deny_count_o
);
  logic s2_load, acc, deny, cap, unused_bits;
  logic [AW-1:0] aw, ca, pa;
  logic [NE-1:0] match_c, perm_c, match_d, match_q, perm_d, perm_q;
  logic s1_valid_d, s1_valid_q, s1_m_d, s1_m_q;
  logic [PLEN-1:0] s1_addr_d, s1_addr_q, rsp_addr_d, rsp_addr_q, fault_addr_d, fault_addr_q;
  logic rsp_valid_d, rsp_valid_q, allow_c, allow_d, allow_q, hit_c, hit_d, hit_q;
  logic [IDX_W-1:0] idx_c, idx_d, idx_q, fault_idx_d, fault_idx_q;
  logic fault_valid_d, fault_valid_q, fault_hit_d, fault_hit_q;
  logic [CNT_W-1:0] deny_count_d, deny_count_q;

  assign s2_load = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = !s1_valid_q || s2_load;
  assign acc = bus.req_valid && bus.req_ready;
  assign deny = rsp_valid_q && bus.rsp_ready && !allow_q;
  // a clear in the same cycle as a denial lets the denial be captured
  assign cap = deny && (!fault_valid_q || fault_clear_i);

  always_comb begin
    match_c = '0;
    perm_c = '0;
    unused_bits = ^bus.req_addr[1:0];
    aw = bus.req_addr[PLEN-1:2];
    ca = '0;
    pa = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ca = AW'(conf_addr_i[i]);
      pa = (i == 0) ? '0 : AW'(conf_addr_i[(i == 0) ? 0 : i - 1]);
      // NAPOT: ca ^ (ca+1) covers the trailing ones and the first zero, i.e. the ignored low bits
      match_c[i] = (bus.req_priv != riscv::PRIV_LVL_M || conf_i[i].locked) && (
        conf_i[i].addr_mode == riscv::NA4   ? aw == ca :
        conf_i[i].addr_mode == riscv::NAPOT ? ((aw ^ ca) & ~(ca ^ (ca + AW'(1)))) == '0 :
        conf_i[i].addr_mode == riscv::TOR   ? pa < ca && aw >= pa && aw < ca : 1'b0);
      perm_c[i] = (bus.req_access & ~conf_i[i].access_type) == '0;
      unused_bits = unused_bits ^ (^conf_i[i].reserved);
    end
    hit_c = 1'b0;
    idx_c = '0;
    allow_c = s1_m_q;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
        allow_c = perm_q[i];
      end
    end
    s1_valid_d = bus.req_ready ? bus.req_valid : s1_valid_q;
    match_d = acc ? match_c : match_q;
    perm_d = acc ? perm_c : perm_q;
    s1_addr_d = acc ? bus.req_addr : s1_addr_q;
    s1_m_d = acc ? bus.req_priv == riscv::PRIV_LVL_M : s1_m_q;
    rsp_valid_d = s2_load ? s1_valid_q : rsp_valid_q;
    allow_d = (s2_load && s1_valid_q) ? allow_c : allow_q;
    hit_d = (s2_load && s1_valid_q) ? hit_c : hit_q;
    idx_d = (s2_load && s1_valid_q) ? idx_c : idx_q;
    rsp_addr_d = (s2_load && s1_valid_q) ? s1_addr_q : rsp_addr_q;
    fault_valid_d = cap || (fault_valid_q && !fault_clear_i);
    fault_addr_d = cap ? rsp_addr_q : fault_addr_q;
    fault_idx_d = cap ? idx_q : fault_idx_q;
    fault_hit_d = cap ? hit_q : fault_hit_q;
    deny_count_d = (deny && !(&deny_count_q)) ? deny_count_q + CNT_W'(1) : deny_count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      match_q <= '0;
      perm_q <= '0;
      s1_addr_q <= '0;
      s1_m_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      allow_q <= 1'b0;
      hit_q <= 1'b0;
      idx_q <= '0;
      rsp_addr_q <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q <= '0;
      fault_idx_q <= '0;
      fault_hit_q <= 1'b0;
      deny_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      match_q <= match_d;
      perm_q <= perm_d;
      s1_addr_q <= s1_addr_d;
      s1_m_q <= s1_m_d;
      rsp_valid_q <= rsp_valid_d;
      allow_q <= allow_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
      rsp_addr_q <= rsp_addr_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q <= fault_addr_d;
      fault_idx_q <= fault_idx_d;
      fault_hit_q <= fault_hit_d;
      deny_count_q <= deny_count_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_allow = allow_q;
  assign bus.rsp_hit = hit_q;
  assign bus.rsp_idx = idx_q;
  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o = fault_addr_q;
  assign fault_idx_o = fault_idx_q;
  assign fault_hit_o = fault_hit_q;
  assign deny_count_o = deny_count_q;
endmodule

// File: tb/tb_pmp_check_pipe.sv
// tb_pmp_check_pipe: directed vector table plus hand-written pipeline sequences for pmp_check_pipe
module tb_pmp_check_pipe;
  localparam int PLEN = 34, PMP_LEN = 32, NR = 16, IDX_W = 4, CNT_W = 16;
  localparam riscv::priv_lvl_t PU = riscv::PRIV_LVL_U, PS = riscv::PRIV_LVL_S, PM = riscv::PRIV_LVL_M;
  localparam logic [2:0] AN = 3'b000, AR = 3'b001, AWR = 3'b010, AX = 3'b100;
  typedef struct {
    int               cs;
    logic [PLEN-1:0]  addr;
    logic [2:0]       acc;
    riscv::priv_lvl_t priv;
    logic             clr;
    logic             allow;
    logic             hit;
    logic [IDX_W-1:0] idx;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [PMP_LEN-1:0] conf_addr [NR];
  riscv::pmpcfg_t conf [NR];
  logic fault_clear, fault_valid, fault_hit;
  logic [PLEN-1:0] fault_addr;
  logic [IDX_W-1:0] fault_idx;
  logic [CNT_W-1:0] deny_count;
  int checks = 0, failures = 0;
  logic m_fv = 1'b0, m_fhit = 1'b0;
  logic [PLEN-1:0] m_faddr = '0;
  logic [IDX_W-1:0] m_fidx = '0;
  int m_cnt = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  pmp_check_pipe_if #(.PLEN(PLEN), .IDX_W(IDX_W)) bus ();

  pmp_check_pipe #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .conf_addr_i(conf_addr), .conf_i(conf),
    .fault_clear_i(fault_clear), .fault_valid_o(fault_valid), .fault_addr_o(fault_addr),
    .fault_idx_o(fault_idx), .fault_hit_o(fault_hit), .deny_count_o(deny_count)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic riscv::pmpcfg_t mk(input logic l, input riscv::pmp_addr_mode_t m, input logic [2:0] a);
    mk = '0;
    mk.locked = l;
    mk.addr_mode = m;
    mk.access_type = a;
  endfunction

  function automatic vec_t v(input int cs, input logic [PLEN-1:0] a, input logic [2:0] ac,
                             input riscv::priv_lvl_t p, input logic clr, input logic al,
                             input logic h, input logic [IDX_W-1:0] ix);
    v.cs = cs; v.addr = a; v.acc = ac; v.priv = p; v.clr = clr; v.allow = al; v.hit = h; v.idx = ix;
  endfunction

  task automatic set_cfg(input int cs);
    for (int i = 0; i < NR; i++) begin
      conf_addr[i] = '0;
      conf[i] = '0;
    end
    case (cs)
      0: begin conf_addr[0] = 32'h1FF; conf[0] = mk(1'b0, riscv::NAPOT, AR); end
      1: begin conf_addr[0] = 32'h400; conf_addr[1] = 32'h800; conf[1] = mk(1'b0, riscv::TOR, 3'b111); end
      2, 3: begin
        conf_addr[2] = 32'h400; conf[2] = mk(cs == 3, riscv::NA4, 3'b101);
        conf_addr[5] = 32'h7FF; conf[5] = mk(1'b0, riscv::NAPOT, 3'b111);
      end
      4: begin
        conf_addr[0] = 32'h800; conf_addr[1] = 32'h400; conf[1] = mk(1'b0, riscv::TOR, 3'b111);
        conf_addr[3] = 32'hFFFF_FFFF; conf[3] = mk(1'b0, riscv::NAPOT, AR);
      end
      default: ;
    endcase
  endtask

  task automatic model_upd(input logic al, input logic h, input logic [IDX_W-1:0] ix,
                           input logic [PLEN-1:0] a, input logic clr);
    if (!al && (!m_fv || clr)) begin
      m_fv = 1'b1; m_faddr = a; m_fidx = ix; m_fhit = h;
    end else if (clr) m_fv = 1'b0;
    if (!al && m_cnt < 65535) m_cnt++;
  endtask

  task automatic chk_fault(input string p);
    chk({p, "_deny_count"}, deny_count, m_cnt);
    chk({p, "_fault_valid"}, fault_valid, m_fv);
    chk({p, "_fault_addr"}, fault_addr, m_faddr);
    chk({p, "_fault_idx"}, fault_idx, m_fidx);
    chk({p, "_fault_hit"}, fault_hit, m_fhit);
  endtask

  task automatic run_vec(input int n, input vec_t t);
    string p;
    p = $sformatf("v%0d", n);
    set_cfg(t.cs);
    bus.req_addr = t.addr; bus.req_access = t.acc; bus.req_priv = t.priv;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    #1 chk({p, "_req_ready"}, bus.req_ready, 1);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk({p, "_early_valid"}, bus.rsp_valid, 0);
    @(posedge clk); @(negedge clk);
    chk({p, "_rsp_valid"}, bus.rsp_valid, 1);
    chk({p, "_allow"}, bus.rsp_allow, t.allow);
    chk({p, "_hit"}, bus.rsp_hit, t.hit);
    chk({p, "_idx"}, bus.rsp_idx, t.idx);
    fault_clear = t.clr;
    model_upd(t.allow, t.hit, t.idx, t.addr, t.clr);
    @(posedge clk); @(negedge clk);
    fault_clear = 1'b0;
    chk_fault(p);
  endtask

  initial begin
    logic [PLEN-1:0] ba [3];
    logic [2:0] bacc [3];
    logic bal [3], bh [3];
    logic fire, seen;
    int na, nr, n;
    ba = '{34'h800, 34'h1000, 34'hFFC};
    bacc = '{AR, AR, AWR};
    bal = '{1'b1, 1'b0, 1'b0};
    bh = '{1'b1, 1'b0, 1'b1};
    vt.push_back(v(0, 34'h800, AR, PU, 0, 1, 1, 0));
    vt.push_back(v(0, 34'h800, AWR, PU, 0, 0, 1, 0));
    vt.push_back(v(0, 34'h1000, AR, PU, 0, 0, 0, 0));
    vt.push_back(v(0, 34'h1000, AR, PM, 0, 1, 0, 0));
    vt.push_back(v(0, 34'hFFC, AR, PU, 0, 1, 1, 0));
    vt.push_back(v(0, 34'h0, AN, PU, 0, 1, 1, 0));
    vt.push_back(v(0, 34'h800, AWR, PM, 0, 1, 0, 0));
    vt.push_back(v(1, 34'h1FFC, AX, PS, 1, 1, 1, 1));
    vt.push_back(v(1, 34'h2000, AX, PS, 0, 0, 0, 0));
    vt.push_back(v(1, 34'h2000, AX, PM, 0, 1, 0, 0));
    vt.push_back(v(1, 34'h1000, AR, PS, 0, 1, 1, 1));
    vt.push_back(v(1, 34'hFFC, AR, PS, 0, 0, 0, 0));
    vt.push_back(v(2, 34'h1000, AWR, PU, 1, 0, 1, 2));
    vt.push_back(v(2, 34'h1000, AR, PU, 0, 1, 1, 2));
    vt.push_back(v(2, 34'h1004, AWR, PU, 0, 1, 1, 5));
    vt.push_back(v(2, 34'h1000, AWR, PM, 0, 1, 0, 0));
    vt.push_back(v(3, 34'h1000, AWR, PM, 0, 0, 1, 2));
    vt.push_back(v(3, 34'h1000, AR, PM, 0, 1, 1, 2));
    vt.push_back(v(3, 34'h1004, AWR, PU, 0, 1, 1, 5));
    vt.push_back(v(4, 34'h1000, AR, PU, 0, 1, 1, 3));
    vt.push_back(v(4, 34'h1000, AX, PU, 0, 0, 1, 3));
    vt.push_back(v(4, 34'h3_FFFF_FFFC, AR, PS, 0, 1, 1, 3));
    set_cfg(0);
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_access = AN; bus.req_priv = PU;
    bus.rsp_ready = 1'b1; fault_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk_fault("rst");
    foreach (vt[i]) run_vec(i, vt[i]);
    // config changes after accept must not affect the in-flight request
    set_cfg(0);
    bus.req_addr = 34'h800; bus.req_access = AR; bus.req_priv = PU; bus.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    set_cfg(99);
    @(posedge clk); @(negedge clk);
    chk("inflight_valid", bus.rsp_valid, 1);
    chk("inflight_allow", bus.rsp_allow, 1);
    chk("inflight_hit", bus.rsp_hit, 1);
    @(posedge clk); @(negedge clk);
    // backpressure: three back-to-back requests, response side stalled for 4 cycles
    set_cfg(0);
    bus.rsp_ready = 1'b0;
    na = 0;
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = na < 3; bus.req_addr = ba[na < 3 ? na : 2]; bus.req_access = bacc[na < 3 ? na : 2];
      #1;
      fire = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        chk($sformatf("bp_hold%0d_allow", c), bus.rsp_allow, bal[0]);
        chk($sformatf("bp_hold%0d_hit", c), bus.rsp_hit, bh[0]);
        chk($sformatf("bp_hold%0d_idx", c), bus.rsp_idx, 0);
      end
      @(posedge clk);
      if (fire) na++;
      @(negedge clk);
    end
    chk("bp_accepts", na, 2);
    chk("bp_ready_low", bus.req_ready, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    nr = 0;
    for (int c = 0; c < 20 && nr < 3; c++) begin
      bus.req_valid = na < 3; bus.req_addr = ba[na < 3 ? na : 2]; bus.req_access = bacc[na < 3 ? na : 2];
      #1;
      fire = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        chk($sformatf("bp_rsp%0d_allow", nr), bus.rsp_allow, bal[nr]);
        chk($sformatf("bp_rsp%0d_hit", nr), bus.rsp_hit, bh[nr]);
        chk($sformatf("bp_rsp%0d_idx", nr), bus.rsp_idx, 0);
        model_upd(bal[nr], bh[nr], '0, ba[nr], 1'b0);
        nr++;
      end
      @(posedge clk);
      if (fire) na++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("bp_completed", nr, 3);
    @(posedge clk); @(negedge clk);
    chk_fault("bp");
    // deny counter saturation with a continuous stream of denials
    bus.req_addr = 34'h800; bus.req_access = AWR; bus.req_priv = PU; bus.req_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 65540; c++) begin
      @(posedge clk); @(negedge clk);
      n += int'(bus.rsp_valid);
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      n += int'(bus.rsp_valid);
    end
    chk("sat_responses", n, 65540);
    m_cnt = 65535;
    chk_fault("sat");
    // reset with both stages full drops both requests
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
    chk("pre_rst_ready", bus.req_ready, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_fv = 1'b0; m_faddr = '0; m_fidx = '0; m_fhit = 1'b0;
    chk("rst2_rsp_valid", bus.rsp_valid, 0);
    chk("rst2_allow", bus.rsp_allow, 0);
    chk("rst2_req_ready", bus.req_ready, 1);
    chk_fault("rst2");
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      seen |= bus.rsp_valid;
    end
    chk("rst2_no_ghost", seen, 0);
    chk("rst2_deny_after", deny_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
